// File: rtl/gfx_pkg.sv
// Shared constants and types for the triangle fetch path.
package gfx_pkg;

  localparam int VTX_WORDS = 15;  // words per assembled triangle
  localparam int WORD_W    = 32;
  localparam int RGB_W     = 24;
  localparam int FRAC_BITS = 16;  // s15.16 coordinates and normals

  // Word positions inside a triangle, in stream order.
  localparam int IDX_X1   = 0;
  localparam int IDX_RGB1 = 3;
  localparam int IDX_RGB2 = 7;
  localparam int IDX_RGB3 = 11;
  localparam int IDX_NX   = 12;
  localparam int IDX_LAST = VTX_WORDS - 1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } fetch_state_t;

  // Colour words carry rgb in the low 24 bits; the top byte is ignored.
  function automatic logic [RGB_W-1:0] rgb_of(input logic [WORD_W-1:0] word);
    return word[RGB_W-1:0];
  endfunction

endpackage

// File: rtl/tri_hold_reg.sv
// Output holding register: presents one assembled triangle downstream with
// valid/stall handshaking and counts delivered triangles.
module tri_hold_reg
  import gfx_pkg::*;
#(
  parameter int NUM_WORDS = VTX_WORDS,
  parameter int CNT_W     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_i,
  input  logic [NUM_WORDS*WORD_W-1:0] words_i,
  input  logic                        pend_done_i,
  input  logic                        stall_i,
  output logic [NUM_WORDS*WORD_W-1:0] v_o,
  output logic [RGB_W-1:0]            color1_o,
  output logic [RGB_W-1:0]            color2_o,
  output logic [RGB_W-1:0]            color3_o,
  output logic                        valid_o,
  output logic                        done_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        slot_free_o
);

  logic [NUM_WORDS*WORD_W-1:0] v_q;
  logic [RGB_W-1:0]            color1_q, color2_q, color3_q;
  logic                        valid_q, done_q;
  logic [CNT_W-1:0]            count_q;
  logic                        xfer;

  // A held triangle leaves when downstream is not stalling.
  assign xfer        = valid_q && !stall_i;
  // The slot can take a new triangle if empty or emptying this edge.
  assign slot_free_o = !valid_q || !stall_i;

  // Load wins over transfer so a simultaneous pair stays back-to-back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q      <= '0;
      color1_q <= '0;
      color2_q <= '0;
      color3_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (load_i) begin
      v_q      <= words_i;
      color1_q <= rgb_of(words_i[IDX_RGB1*WORD_W +: WORD_W]);
      color2_q <= rgb_of(words_i[IDX_RGB2*WORD_W +: WORD_W]);
      color3_q <= rgb_of(words_i[IDX_RGB3*WORD_W +: WORD_W]);
      done_q   <= pend_done_i;
      valid_q  <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  // Delivered-triangle counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (xfer) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign v_o      = v_q;
  assign color1_o = color1_q;
  assign color2_o = color2_q;
  assign color3_o = color3_q;
  assign valid_o  = valid_q;
  assign done_o   = done_q;
  assign count_o  = count_q;

endmodule

// File: rtl/tri_fetch.sv
// Triangle fetch: assembles 15-word triangles from a word stream and hands
// them to the holding register; assembly of the next triangle overlaps with
// the current one being held downstream.
module tri_fetch
  import gfx_pkg::*;
#(
  parameter int NUM_WORDS = VTX_WORDS,
  parameter int CNT_W     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WORD_W-1:0]           wr_data,
  input  logic                        wr_valid,
  input  logic                        wr_last,
  output logic                        wr_ready,
  output logic [NUM_WORDS*WORD_W-1:0] v_out,
  output logic [RGB_W-1:0]            color_out1,
  output logic [RGB_W-1:0]            color_out2,
  output logic [RGB_W-1:0]            color_out3,
  output logic                        out_data_valid,
  input  logic                        stall_in,
  output logic                        done_out,
  output logic [CNT_W-1:0]            tri_count,
  output logic                        protocol_err
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_WORDS - 1);

  fetch_state_t                state_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        pend_done_q;
  logic                        perr_q;
  logic [WORD_W-1:0]           buf_q [NUM_WORDS];
  logic [NUM_WORDS*WORD_W-1:0] buf_flat;
  logic                        accept;
  logic                        load;
  logic                        slot_free;

  assign wr_ready     = (state_q == S_FILL);
  assign accept       = wr_valid && wr_ready;
  assign load         = (state_q == S_FULL) && slot_free;
  assign protocol_err = perr_q;

  // Capture each accepted word at its stream position.
  // NOTE: the assembly buffer has no reset; every slot is rewritten before a
  // triangle can be loaded from it, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (accept) begin
      buf_q[idx_q] <= wr_data;
    end
  end

  genvar g;
  for (g = 0; g < NUM_WORDS; g++) begin : g_flat
    assign buf_flat[g*WORD_W +: WORD_W] = buf_q[g];
  end

  // Assembly FSM: fill 15 words, then wait for the output slot.
  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values of idx_q/state_q regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      pend_done_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept) begin
            if (idx_q == IDX_END) begin
              idx_q       <= '0;
              pend_done_q <= wr_last;
              state_q     <= S_FULL;
            end else if (wr_last) begin
              // Early end-of-frame: drop the partial triangle and resync.
              idx_q  <= '0;
              perr_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (load) begin
            state_q <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  tri_hold_reg #(
    .NUM_WORDS(NUM_WORDS),
    .CNT_W    (CNT_W)
  ) u_hold (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load),
    .words_i    (buf_flat),
    .pend_done_i(pend_done_q),
    .stall_i    (stall_in),
    .v_o        (v_out),
    .color1_o   (color_out1),
    .color2_o   (color_out2),
    .color3_o   (color_out3),
    .valid_o    (out_data_valid),
    .done_o     (done_out),
    .count_o    (tri_count),
    .slot_free_o(slot_free)
  );

endmodule

// File: tb/tb_tri_fetch.sv
// Self-checking bench for tri_fetch: directed scenarios plus randomized
// traffic against a transaction-level scoreboard.
module tb_tri_fetch;

  localparam int NW = 15;
  localparam int VW = NW * 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_last = 1'b0;
  logic          stall_in = 1'b0;

  logic          wr_ready, out_data_valid, done_out, protocol_err;
  logic [VW-1:0] v_out;
  logic [23:0]   color_out1, color_out2, color_out3;
  logic [15:0]   tri_count;

  logic          wr_ready2, out_data_valid2, done_out2, protocol_err2;
  logic [VW-1:0] v_out2;
  logic [23:0]   color_out1_2, color_out2_2, color_out3_2;
  logic [1:0]    tri_count2;

  tri_fetch #(.NUM_WORDS(15), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_last(wr_last), .wr_ready(wr_ready), .v_out(v_out),
    .color_out1(color_out1), .color_out2(color_out2), .color_out3(color_out3),
    .out_data_valid(out_data_valid), .stall_in(stall_in), .done_out(done_out),
    .tri_count(tri_count), .protocol_err(protocol_err)
  );

  // Narrow-counter instance sharing the same stimulus, to exercise wrap.
  tri_fetch #(.NUM_WORDS(15), .CNT_W(2)) u_dut_w2 (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_last(wr_last), .wr_ready(wr_ready2), .v_out(v_out2),
    .color_out1(color_out1_2), .color_out2(color_out2_2), .color_out3(color_out3_2),
    .out_data_valid(out_data_valid2), .stall_in(stall_in), .done_out(done_out2),
    .tri_count(tri_count2), .protocol_err(protocol_err2)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          last;
    logic [VW-1:0] words;
  } tri_t;

  tri_t          exp_q[$];
  logic [31:0]   cur_q[$];
  int            exp_cnt = 0;
  logic          exp_perr = 1'b0;
  int            total = 0;
  int            bad = 0;
  int            stall_mode = 0;  // 0: never, 1: always, 2: random
  logic          prev_hold = 1'b0;
  logic [VW-1:0] prev_v;
  logic          prev_done;
  logic [23:0]   prev_c1;
  tri_t          t_mon;

  task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_tri();
    logic [VW-1:0] w;
    for (int i = 0; i < NW; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Stall driver, applied just after each rising edge.
  always @(posedge clock) begin
    #2;
    case (stall_mode)
      0:       stall_in = 1'b0;
      1:       stall_in = 1'b1;
      default: stall_in = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Scoreboard: models assembly by word counting and checks every transfer.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      cur_q.delete();
      exp_cnt   = 0;
      exp_perr  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      check("tri_count", tri_count, exp_cnt[15:0]);
      check("tri_count_w2", tri_count2, exp_cnt[1:0]);
      check("protocol_err", protocol_err, exp_perr);
      if (prev_hold) begin
        check("hold_v_out", v_out, prev_v);
        check("hold_done", done_out, prev_done);
        check("hold_color1", color_out1, prev_c1);
      end
      if (out_data_valid && !stall_in) begin
        check("xfer_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          t_mon = exp_q.pop_front();
          check("xfer_v_out", v_out, t_mon.words);
          check("xfer_color1", color_out1, t_mon.words[3*32 +: 24]);
          check("xfer_color2", color_out2, t_mon.words[7*32 +: 24]);
          check("xfer_color3", color_out3, t_mon.words[11*32 +: 24]);
          check("xfer_done", done_out, t_mon.last);
        end
        exp_cnt++;
      end
      if (wr_valid && wr_ready) begin
        cur_q.push_back(wr_data);
        if (cur_q.size() == NW) begin
          for (int i = 0; i < NW; i++) t_mon.words[i*32 +: 32] = cur_q[i];
          t_mon.last = wr_last;
          exp_q.push_back(t_mon);
          cur_q.delete();
        end else if (wr_last) begin
          cur_q.delete();
          exp_perr = 1'b1;
        end
      end
      prev_hold = out_data_valid && stall_in;
      prev_v    = v_out;
      prev_done = done_out;
      prev_c1   = color_out1;
    end
  end

  // Called and returns just after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    wr_data  = d;
    wr_last  = last;
    wr_valid = 1'b1;
    @(negedge clock);
    while (!wr_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    check("wr_ready_wait", wr_ready, 1'b1);
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'($urandom);  // must be ignored while wr_valid is low
    wr_data  = $urandom;
  endtask

  task automatic send_tri(input logic [VW-1:0] w, input logic last, input int gap);
    for (int i = 0; i < NW; i++) begin
      send_word(w[i*32 +: 32], last && (i == NW - 1));
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_data_valid) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", out_data_valid, 1'b0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] wa, wb;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", out_data_valid, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_count", tri_count, 0);
    check("rst_perr", protocol_err, 1'b0);
    check("rst_v_out", v_out, 0);
    check("rst_color1", color_out1, 0);
    check("rst_wr_ready", wr_ready, 1'b1);
    reset = 1'b1;
    idle(1);

    // Single triangle with known words.
    for (int k = 0; k < NW; k++) wa[k*32 +: 32] = 32'h10000 * (k + 1);
    send_tri(wa, 1'b1, 0);
    check("t1_valid_n", out_data_valid, 1'b0);
    check("t1_ready_full", wr_ready, 1'b0);
    idle(1);
    check("t1_valid_n1", out_data_valid, 1'b1);
    check("t1_v_out", v_out, wa);
    check("t1_color1", color_out1, 24'h040000);
    check("t1_color2", color_out2, 24'h080000);
    check("t1_color3", color_out3, 24'h0C0000);
    check("t1_done", done_out, 1'b1);
    check("t1_count_pre", tri_count, 0);
    idle(1);
    check("t1_valid_drop", out_data_valid, 1'b0);
    check("t1_done_clear", done_out, 1'b0);
    check("t1_count", tri_count, 1);
    check("t1_ready_back", wr_ready, 1'b1);

    // Stall hold with a second triangle assembling behind it.
    stall_mode = 1;
    wa = rand_tri();
    wb = rand_tri();
    send_tri(wa, 1'b0, 0);
    idle(1);
    check("st_valid_a", out_data_valid, 1'b1);
    check("st_v_out_a", v_out, wa);
    send_tri(wb, 1'b1, 0);
    check("st_ready_low", wr_ready, 1'b0);
    idle(2);
    check("st_still_a", v_out, wa);
    check("st_count_held", tri_count, 1);
    stall_mode = 0;
    idle(1);
    check("st_b2b_valid", out_data_valid, 1'b1);
    check("st_b2b_v_out", v_out, wb);
    check("st_b2b_done", done_out, 1'b1);
    check("st_count_a", tri_count, 2);
    idle(1);
    check("st_valid_end", out_data_valid, 1'b0);
    check("st_count_b", tri_count, 3);

    // Back-to-back, done only on the fourth.
    for (int t = 0; t < 4; t++) send_tri(rand_tri(), t == 3, 0);
    drain();
    check("b2b_count", tri_count, 7);

    // Protocol error: wr_last on word index 6.
    for (int i = 0; i < 7; i++) send_word($urandom, i == 6);
    check("pe_flag", protocol_err, 1'b1);
    check("pe_no_valid", out_data_valid, 1'b0);
    check("pe_ready", wr_ready, 1'b1);
    send_tri(rand_tri(), 1'b1, 0);
    drain();
    check("pe_count", tri_count, 8);
    check("pe_sticky", protocol_err, 1'b1);

    // Asynchronous reset in the middle of a triangle.
    for (int i = 0; i < 8; i++) send_word($urandom, 1'b0);
    reset = 1'b0;
    #1;
    check("ar_valid", out_data_valid, 1'b0);
    check("ar_v_out", v_out, 0);
    check("ar_color1", color_out1, 0);
    check("ar_count", tri_count, 0);
    check("ar_count_w2", tri_count2, 0);
    check("ar_perr", protocol_err, 1'b0);
    check("ar_done", done_out, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(1);
    wa = rand_tri();
    send_tri(wa, 1'b1, 0);
    idle(1);
    check("ar_tri_v_out", v_out, wa);
    drain();
    check("ar_tri_count", tri_count, 1);
    check("ar_tri_count_w2", tri_count2, 1);

    // Randomized traffic with random stalls, gaps and early-last errors.
    stall_mode = 2;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(1, 14);
        for (int i = 0; i < k; i++) send_word($urandom, i == k - 1);
      end
      send_tri(rand_tri(), 1'($urandom_range(0, 1)), 2);
    end
    stall_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tri_fetch.md
Name: tri_fetch

Overview:
- Feeds the vertex transform stage with triangles assembled from a 32-bit word stream (DMA/bus write side).
- Collects 15 words per triangle (x1 y1 z1 rgb1 x2 y2 z2 rgb2 x3 y3 z3 rgb3 nx ny nz; coordinates and normals in s15.16 fixed point).
- Presents the assembled triangle as a parallel bundle with valid/stall/done signalling.
- Double-buffered: assembly of the next triangle overlaps with holding the current one.

Parameters:
NUM_WORDS, 15, words per triangle; fixed, other values unsupported.
CNT_W, 16, width of delivered-triangle counter.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
wr_data  in  32  stream word
wr_valid  in  1  wr_data valid this cycle
wr_last  in  1  qualifies word as last triangle of the frame (valid only with wr_valid)
wr_ready  out  1  block accepts a word this cycle
v_out  out  32x15  triangle words, index 0..14 in stream order
color_out1/2/3  out  24 each  rgb1/rgb2/rgb3 bits [23:0]
out_data_valid  out  1  v_out/color/done_out hold a triangle
stall_in  in  1  downstream not accepting
done_out  out  1  held triangle is last of frame
tri_count  out  CNT_W  triangles delivered since reset
protocol_err  out  1  sticky: wr_last on a word other than index 14

Behaviour:
- Reset (async, reset=0): all outputs 0, word index 0, state S_FILL; v_out/colors cleared. Mid-triangle reset discards the partial triangle.
- Word accept: wr_valid && wr_ready at a rising edge. The word is written to assembly buffer[idx] and idx increments.
- wr_ready = (state == S_FILL); combinational from state only.
- States:
  - S_FILL: accept words. Accepting idx 14 goes to S_FULL, latches wr_last into the pending done flag, and resets idx to 0.
  - S_FULL: wr_ready=0. Load the output when the slot is free: !out_data_valid || !stall_in.
    - On load: v_out takes the buffer, colors take buffer[3]/[7]/[11][23:0], done_out takes the pending flag, out_data_valid=1, return to S_FILL.
    - Otherwise stay in S_FULL.
- Output transfer: out_data_valid && !stall_in at a rising edge.
  - tri_count increments on each transfer and wraps modulo 2^CNT_W.
  - If a transfer happens without a simultaneous load, out_data_valid goes to 0 next cycle.
  - A simultaneous transfer and load is back-to-back: out_data_valid stays 1 with new data.
- While out_data_valid && stall_in, v_out/colors/done_out are stable. Downstream samples them only on transfer.
- Latency: last word accepted at edge N gives out_data_valid=1 after edge N+1 (if the slot is free). Sustained throughput is 1 triangle per 16 cycles.
- done_out is valid only while out_data_valid=1. It clears on a transfer that has no simultaneous load.
- wr_last with idx != 14:
  - The word is accepted, the partial triangle is discarded, idx resets to 0.
  - protocol_err sets and stays set until reset.
  - Nothing is emitted for that triangle.
- wr_last is ignored when wr_valid=0.
- wr_valid while wr_ready=0: the word is not consumed; the source must hold it.

Decomposition:
- Shared package gfx_pkg:
  - VTX_WORDS=15
  - word index constants (IDX_X1=0, IDX_RGB1=3, IDX_RGB2=7, IDX_RGB3=11, IDX_NX=12)
  - FRAC_BITS=16
  - typedef fetch_state_t {S_FILL, S_FULL}
- Sub-module tri_hold_reg: the output holding register with the valid/stall/transfer logic and tri_count.
- Assembly buffer and FSM stay in tri_fetch.

Test Plan:
- Single triangle: 15 words 0x10000·k (k=1..15), wr_last on word 15, stall_in=0.
  - out_data_valid=1 for exactly one cycle, starting the cycle after the 15th accept.
  - v_out[k-1]=0x10000·k; color_out1=0x040000 & 0xFFFFFF; done_out=1; tri_count=1.
- Stall hold: deliver a triangle with stall_in=1 for 10 cycles while streaming a second triangle.
  - Outputs stay frozen; wr_ready drops to 0 after the 15th word of triangle 2.
  - On stall release: triangle 1 transfers, triangle 2 loads the same edge, out_data_valid stays 1, tri_count=1 then 2.
- Back-to-back: 4 triangles continuous, stall_in=0.
  - 4 transfers; tri_count=4; only the 4th has done_out=1 (wr_last on the final word only).
- Protocol error: wr_last on word index 6.
  - protocol_err=1 and stays 1; no out_data_valid pulse.
  - The next 15 words form a correct triangle with idx restarted at 0.
- Async reset mid-triangle: after 8 words, reset=0 for 2 cycles.
  - All outputs 0 immediately; after release a full 15-word triangle emits correctly and tri_count=1.
- Counter wrap (CNT_W=2): 5 triangles give tri_count sequence 1,2,3,0,1.
